// File: rtl/prop_monitor_pkg.sv
// Shared types for the multi-channel "always" property monitor.
package prop_monitor_pkg;

  // How a channel evaluates its property once started.
  typedef enum logic [1:0] {
    ALWAYS       = 2'b00,
    NEXT_ALWAYS  = 2'b01,
    BOUNDED      = 2'b10,
    NEXT_BOUNDED = 2'b11
  } mode_e;

  // Per-channel monitor state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam int MODE_W = 2;

  // First evaluation happens one cycle after the start request.
  function automatic logic isNext(input mode_e m);
    return (m == NEXT_ALWAYS) || (m == NEXT_BOUNDED);
  endfunction

  // Channel stops with a pass once its window has been evaluated clean.
  function automatic logic isBounded(input mode_e m);
    return (m == BOUNDED) || (m == NEXT_BOUNDED);
  endfunction

endpackage

// File: rtl/prop_monitor_chan.sv
// One monitor channel: start/arm/check FSM, evaluation window counter and
// saturating violation counter. All outputs come straight from flops.
module prop_monitor_chan
  import prop_monitor_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              start_i,
  input  logic              p_i,
  input  logic              dis_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [WIN_W-1:0]  win_i,
  output logic              active_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic [CNT_W-1:0]  fail_cnt_o
);

  state_e             r_state;
  logic               r_bounded;
  logic [WIN_W-1:0]   r_win;
  logic [WIN_W-1:0]   r_evalCnt;
  logic               r_active;
  logic               r_pass;
  logic               r_fail;
  logic [CNT_W-1:0]   r_failCnt;

  mode_e              w_mode;
  logic               w_accept;
  logic               w_evalNow;
  logic               w_bounded;
  logic               w_violate;
  logic               w_windowDone;
  logic [WIN_W-1:0]   w_startWin;
  logic [WIN_W-1:0]   w_winEff;
  logic [WIN_W-1:0]   w_evalNum;
  logic [CNT_W-1:0]   w_failCntInc;

  assign w_mode     = mode_e'(mode_i);

  // A zero-length window still needs one clean evaluation to pass.
  assign w_startWin = (win_i == '0) ? WIN_W'(1) : win_i;

  // A start is only taken from IDLE, and a disabled start is dropped.
  assign w_accept   = (r_state == IDLE) && start_i && !dis_i;

  // Evaluate on an immediate-mode start cycle, or in ARM/CHECK unless disabled
  // (disable wins over a simultaneous violation).
  assign w_evalNow  = (r_state == IDLE) ? (w_accept && !isNext(w_mode))
                                        : (((r_state == ARM) || (r_state == CHECK)) && !dis_i);

  // On the start cycle the mode/window come from the inputs, later from the latches.
  assign w_bounded  = (r_state == IDLE) ? isBounded(w_mode) : r_bounded;
  assign w_winEff   = (r_state == IDLE) ? w_startWin : r_win;

  // Ordinal of the evaluation happening this cycle; held at max in unbounded runs.
  assign w_evalNum  = (r_state == CHECK)
                      ? ((r_evalCnt == '1) ? r_evalCnt : r_evalCnt + 1'b1)
                      : WIN_W'(1);

  assign w_violate    = w_evalNow && !p_i;
  assign w_windowDone = w_evalNow && p_i && w_bounded && (w_evalNum >= w_winEff);
  assign w_failCntInc = (r_failCnt == '1) ? r_failCnt : r_failCnt + 1'b1;

  // Channel FSM with registered verdict pulses, activity flag and fail counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bounded <= 1'b0;
      r_win     <= '0;
      r_evalCnt <= '0;
      r_active  <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_failCnt <= '0;
    end else begin
      r_pass <= 1'b0;
      r_fail <= 1'b0;
      if (clr_i) begin
        r_state   <= IDLE;
        r_active  <= 1'b0;
        r_evalCnt <= '0;
        r_failCnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_active <= 1'b0;
            if (w_accept) begin
              r_bounded <= isBounded(w_mode);
              r_win     <= w_startWin;
              if (isNext(w_mode)) begin
                r_state  <= ARM;
                r_active <= 1'b1;
              end else if (w_violate) begin
                r_fail    <= 1'b1;
                r_failCnt <= w_failCntInc;
              end else if (w_windowDone) begin
                r_pass <= 1'b1;
              end else begin
                r_state   <= CHECK;
                r_evalCnt <= w_evalNum;
                r_active  <= 1'b1;
              end
            end
          end
          ARM, CHECK: begin
            if (dis_i) begin
              r_state  <= IDLE;
              r_active <= 1'b0;
            end else if (w_violate) begin
              r_fail    <= 1'b1;
              r_failCnt <= w_failCntInc;
              r_state   <= IDLE;
              r_active  <= 1'b0;
            end else if (w_windowDone) begin
              r_pass   <= 1'b1;
              r_state  <= IDLE;
              r_active <= 1'b0;
            end else begin
              r_state   <= CHECK;
              r_evalCnt <= w_evalNum;
              r_active  <= 1'b1;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign active_o   = r_active;
  assign pass_o     = r_pass;
  assign fail_o     = r_fail;
  assign fail_cnt_o = r_failCnt;

endmodule

// File: rtl/prop_monitor_mc.sv
// Multi-channel "always" property monitor: NCH independent channels plus a
// combined fail flag for the assertion status collector.
module prop_monitor_mc
  import prop_monitor_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic [NCH-1:0]        start_i,
  input  logic [NCH-1:0]        p_i,
  input  logic [NCH-1:0]        dis_i,
  input  logic [MODE_W*NCH-1:0] mode_i,
  input  logic [WIN_W-1:0]      win_i,
  output logic [NCH-1:0]        active_o,
  output logic [NCH-1:0]        pass_o,
  output logic [NCH-1:0]        fail_o,
  output logic [NCH*CNT_W-1:0]  fail_cnt_o,
  output logic                  any_fail_o
);

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    prop_monitor_chan #(
      .CNT_W (CNT_W),
      .WIN_W (WIN_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (clr_i),
      .start_i    (start_i[k]),
      .p_i        (p_i[k]),
      .dis_i      (dis_i[k]),
      .mode_i     (mode_i[k*MODE_W +: MODE_W]),
      .win_i      (win_i),
      .active_o   (active_o[k]),
      .pass_o     (pass_o[k]),
      .fail_o     (fail_o[k]),
      .fail_cnt_o (fail_cnt_o[k*CNT_W +: CNT_W])
    );
  end

  assign any_fail_o = |fail_o;

endmodule

// File: tb/tb_prop_monitor_mc.sv
// Bench for prop_monitor_mc: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_prop_monitor_mc;

  localparam int NCH     = 4;
  localparam int CNT_W   = 2;
  localparam int WIN_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 clr_i;
  logic [NCH-1:0]       start_i;
  logic [NCH-1:0]       p_i;
  logic [NCH-1:0]       dis_i;
  logic [2*NCH-1:0]     mode_i;
  logic [WIN_W-1:0]     win_i;
  logic [NCH-1:0]       active_o;
  logic [NCH-1:0]       pass_o;
  logic [NCH-1:0]       fail_o;
  logic [NCH*CNT_W-1:0] fail_cnt_o;
  logic                 any_fail_o;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  // Model: a run is "started at some cycle, first evaluated at mFirst, needs
  // mNeed clean evaluations (bounded)"; outputs derive from that bookkeeping.
  bit             mRun     [NCH];
  bit             mBounded [NCH];
  int             mNeed    [NCH];
  int             mDone    [NCH];
  int             mFirst   [NCH];
  int             mCnt     [NCH];
  bit [NCH-1:0]   eActive, ePass, eFail;

  always #5 clk = ~clk;

  prop_monitor_mc #(.NCH(NCH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr_i),
    .start_i    (start_i),
    .p_i        (p_i),
    .dis_i      (dis_i),
    .mode_i     (mode_i),
    .win_i      (win_i),
    .active_o   (active_o),
    .pass_o     (pass_o),
    .fail_o     (fail_o),
    .fail_cnt_o (fail_cnt_o),
    .any_fail_o (any_fail_o)
  );

  function automatic void compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void resetModel();
    for (int k = 0; k < NCH; k++) begin
      mRun[k] = 0;
      mCnt[k] = 0;
      mDone[k] = 0;
    end
    eActive = '0;
    ePass   = '0;
    eFail   = '0;
  endfunction

  // Predict the outputs of the next cycle from the inputs of this cycle.
  function automatic void modelStep();
    ePass = '0;
    eFail = '0;
    for (int k = 0; k < NCH; k++) begin
      if (clr_i) begin
        mRun[k] = 0;
        mCnt[k] = 0;
      end else begin
        if (mRun[k]) begin
          if (dis_i[k]) mRun[k] = 0;
        end else if (start_i[k] && !dis_i[k]) begin
          mRun[k]     = 1;
          mBounded[k] = mode_i[2*k+1];
          mNeed[k]    = (win_i == 0) ? 1 : int'(win_i);
          mDone[k]    = 0;
          mFirst[k]   = mode_i[2*k] ? cyc + 1 : cyc;
        end
        if (mRun[k] && cyc >= mFirst[k]) begin
          mDone[k]++;
          if (!p_i[k]) begin
            eFail[k] = 1;
            if (mCnt[k] < CNT_MAX) mCnt[k]++;
            mRun[k] = 0;
          end else if (mBounded[k] && mDone[k] >= mNeed[k]) begin
            ePass[k] = 1;
            mRun[k]  = 0;
          end
        end
      end
      eActive[k] = mRun[k];
    end
  endfunction

  task automatic checkOutput();
    compare("active_o", active_o, eActive);
    compare("pass_o", pass_o, ePass);
    compare("fail_o", fail_o, eFail);
    compare("any_fail_o", any_fail_o, |eFail);
    for (int k = 0; k < NCH; k++)
      compare($sformatf("fail_cnt[%0d]", k), fail_cnt_o[k*CNT_W +: CNT_W], mCnt[k]);
  endtask

  // Check the current cycle's outputs, then drive and model the next cycle.
  task automatic applyStimulus(input logic [NCH-1:0] st, input logic [NCH-1:0] pv,
                               input logic [NCH-1:0] dv, input logic [2*NCH-1:0] md,
                               input logic [WIN_W-1:0] w, input logic cl);
    @(negedge clk);
    checkOutput();
    start_i = st;
    p_i     = pv;
    dis_i   = dv;
    mode_i  = md;
    win_i   = w;
    clr_i   = cl;
    modelStep();
    cyc++;
  endtask

  task automatic doReset();
    @(negedge clk);
    checkOutput();
    start_i = '0;
    p_i     = '1;
    dis_i   = '0;
    clr_i   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    compare("async_rst_active", active_o, 0);
    compare("async_rst_fail", fail_o, 0);
    compare("async_rst_cnt", fail_cnt_o, 0);
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    nFails++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    rst_n   = 1'b0;
    clr_i   = 1'b0;
    start_i = '0;
    p_i     = '1;
    dis_i   = '0;
    mode_i  = '0;
    win_i   = '0;
    resetModel();
    repeat (3) @(negedge clk);
    compare("reset_active", active_o, 0);
    compare("reset_pulses", {pass_o, fail_o, any_fail_o}, 0);
    compare("reset_cnt", fail_cnt_o, 0);
    rst_n = 1'b1;

    // ALWAYS on ch0: violation at 10 reported at 11
    for (int c = 0; c <= 11; c++) begin
      applyStimulus((c == 5) ? 4'b0001 : 4'b0000, (c == 10) ? 4'b1110 : 4'b1111, '0, '0, '0, 0);
      if (c >= 6 && c <= 10) compare("always_active0", active_o[0], 1);
      if (c == 11) begin
        compare("always_fail0", fail_o[0], 1);
        compare("always_cnt0", fail_cnt_o[0 +: CNT_W], 1);
        compare("always_idle0", active_o[0], 0);
      end
    end
    // ALWAYS on ch0: violation on the start cycle itself
    for (int c = 0; c <= 6; c++) begin
      applyStimulus((c == 5) ? 4'b0001 : 4'b0000, (c == 5) ? 4'b1110 : 4'b1111, '0, '0, '0, 0);
      if (c == 6) begin
        compare("always_now_fail0", fail_o[0], 1);
        compare("always_now_cnt0", fail_cnt_o[0 +: CNT_W], 2);
        compare("always_now_idle0", active_o[0], 0);
      end
    end

    // NEXT_ALWAYS on ch1: p low on the start cycle is not evaluated
    for (int c = 0; c <= 10; c++) begin
      applyStimulus((c == 5) ? 4'b0010 : 4'b0000, (c == 5) ? 4'b1101 : 4'b1111,
                    (c == 9) ? 4'b0010 : 4'b0000, 8'b0000_0100, '0, 0);
      if (c >= 6 && c <= 9) begin
        compare("next_nofail1", fail_o[1], 0);
        compare("next_active1", active_o[1], 1);
      end
      if (c == 10) begin
        compare("next_abort1", active_o[1], 0);
        compare("next_cnt1", fail_cnt_o[CNT_W +: CNT_W], 0);
      end
    end
    for (int c = 0; c <= 7; c++) begin
      applyStimulus((c == 5) ? 4'b0010 : 4'b0000, (c == 6) ? 4'b1101 : 4'b1111, '0, 8'b0000_0100, '0, 0);
      if (c == 6) compare("next_arm_nofail1", fail_o[1], 0);
      if (c == 7) begin
        compare("next_fail1", fail_o[1], 1);
        compare("next_fail_cnt1", fail_cnt_o[CNT_W +: CNT_W], 1);
      end
    end

    // BOUNDED on ch2: window 3 then window 0
    for (int c = 0; c <= 8; c++) begin
      applyStimulus((c == 5) ? 4'b0100 : 4'b0000, 4'b1111, '0, 8'b0010_0000, 4'd3, 0);
      if (c == 7) begin
        compare("bnd3_active2", active_o[2], 1);
        compare("bnd3_early2", pass_o[2], 0);
      end
      if (c == 8) begin
        compare("bnd3_pass2", pass_o[2], 1);
        compare("bnd3_idle2", active_o[2], 0);
      end
    end
    for (int c = 0; c <= 6; c++) begin
      applyStimulus((c == 5) ? 4'b0100 : 4'b0000, 4'b1111, '0, 8'b0010_0000, 4'd0, 0);
      if (c == 6) begin
        compare("bnd0_pass2", pass_o[2], 1);
        compare("bnd0_idle2", active_o[2], 0);
      end
    end

    // Disable on ch3: beats a simultaneous violation; disabled start ignored
    for (int c = 0; c <= 9; c++) begin
      applyStimulus((c == 5) ? 4'b1000 : 4'b0000, (c == 8) ? 4'b0111 : 4'b1111,
                    (c == 8) ? 4'b1000 : 4'b0000, '0, '0, 0);
      if (c == 8) compare("dis_active3", active_o[3], 1);
      if (c == 9) begin
        compare("dis_idle3", active_o[3], 0);
        compare("dis_nofail3", fail_o[3], 0);
        compare("dis_cnt3", fail_cnt_o[3*CNT_W +: CNT_W], 0);
      end
    end
    for (int c = 0; c <= 6; c++) begin
      applyStimulus((c == 5) ? 4'b1000 : 4'b0000, 4'b1111, (c == 5) ? 4'b1000 : 4'b0000, '0, '0, 0);
      if (c == 6) compare("dis_start3", active_o[3], 0);
    end

    // Saturation on ch0 (already at 2) with ch1 running, then clear
    for (int c = 0; c <= 5; c++) begin
      applyStimulus((c < 5) ? ((c == 0) ? 4'b0011 : 4'b0001) : 4'b0000, 4'b1110, '0, '0, '0, 0);
      if (c == 5) begin
        compare("sat_cnt0", fail_cnt_o[0 +: CNT_W], 3);
        compare("sat_active1", active_o[1], 1);
      end
    end
    applyStimulus(4'b0001, 4'b1110, '0, '0, '0, 1);
    applyStimulus('0, 4'b1111, '0, '0, '0, 0);
    compare("clr_active", active_o, 0);
    compare("clr_cnt", fail_cnt_o, 0);
    compare("clr_nofail", fail_o, 0);

    // Asynchronous reset while ch0 is checking
    for (int c = 0; c <= 3; c++)
      applyStimulus((c == 1) ? 4'b0001 : 4'b0000, 4'b1111, '0, '0, '0, 0);
    compare("pre_rst_active0", active_o[0], 1);
    doReset();
    for (int c = 0; c < 3; c++) applyStimulus('0, 4'b1111, '0, '0, '0, 0);
    compare("post_rst_active", active_o, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [NCH-1:0] st, pv, dv;
      for (int k = 0; k < NCH; k++) begin
        st[k] = ($urandom_range(0, 3) == 0);
        pv[k] = ($urandom_range(0, 15) != 0);
        dv[k] = ($urandom_range(0, 31) == 0);
      end
      if (i % 1500 == 750) doReset();
      applyStimulus(st, pv, dv, (2*NCH)'($urandom), WIN_W'($urandom_range(0, 6)),
                    ($urandom_range(0, 255) == 0));
    end
    @(negedge clk);
    checkOutput();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
